sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
Parametrised multi-digit seven-segment scan controller that replaces the fixed 8-digit inline scanner in the board top level. It time-multiplexes N hex digits onto shared segment lines. It adds a runtime refresh divider, tear-free shadow loading, per-digit blanking and decimal points, leading-zero suppression and anti-ghosting dead time. Segment and anode outputs are registered together, so a digit's segments never lag its anode.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
DIV_W, 16, width of refresh_div
DEADTIME, 4, clk cycles all anodes are held inactive at the start of each digit slot
AN_ACTIVE_LOW, 1, 1 = anode asserted as 0
SEG_ACTIVE_LOW, 1, 1 = segment lit as 0 (applies to sev_out and dp_out)

Ports:
clk  input  1  single system clock
Rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
refresh_div  input  DIV_W  clk cycles per digit slot; 0 is treated as 1
value  input  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost
load  input  1  1-cycle strobe capturing value, dp_mask and blank_mask into the shadow
dp_mask  input  NUM_DIGITS  decimal point on per digit
blank_mask  input  NUM_DIGITS  force digit dark
lz_en  input  1  leading-zero suppression enable
an  output  NUM_DIGITS  one-hot anode drive, polarity per AN_ACTIVE_LOW
sev_out  output  7  segments {a,b,c,d,e,f,g}; bit6 = a, bit0 = g
dp_out  output  1  decimal point segment
frame_done  output  1  1-cycle pulse when digit index wraps from NUM_DIGITS-1 to 0

Behaviour:
- Reset (Rst=0 on a clk edge) sets the following. Slot counter = 0. Digit index = 0. Shadow, active value, active masks and pending = 0. an = all inactive. sev_out = all unlit. dp_out = unlit. frame_done = 0.
- Slot counter: div_eff = max(refresh_div,1). The counter runs 0..div_eff-1.
  - tick = (counter >= div_eff-1). On tick the counter returns to 0.
  - Using >= makes the counter wrap on the next cycle if refresh_div is lowered mid-slot.
- Digit index: increments on tick. It wraps from NUM_DIGITS-1 to 0. On wrap, frame_done = 1 for exactly that cycle.
- Shadow/active:
  - load sets shadow <= inputs and pending <= 1.
  - On a wrap cycle with pending = 1: active <= shadow and pending <= 0.
  - If load coincides with a wrap cycle: active <= the incoming inputs directly, and pending <= 0.
  - The displayed content therefore changes only at frame boundaries and never tears.
- Lit decision for digit i (combinational from active state):
  - A digit is dark if blank_mask[i] = 1, or if it is leading-zero suppressed.
  - Leading-zero suppression applies when lz_en = 1, i > 0, and all nibbles i..NUM_DIGITS-1 are 0. Digit 0 always shows.
  - dp_mask is honoured even on suppressed digits. It is not honoured on blank_mask digits.
- Output register, one cycle after the index update:
  - an asserts the bit of the current index, unless the digit is dark (no anode) or in dead time.
  - Dead time: the first min(DEADTIME, div_eff-1) cycles of each slot, where all anodes are inactive. With div_eff = 1 there is no dead time.
  - sev_out/dp_out show the decoded current digit in the same cycle that an asserts.
- Decode table (active-low form):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - Inverted when SEG_ACTIVE_LOW = 0.
- Reset mid-slot aborts immediately. There is no partial-frame completion and no pending carry-over.

Decomposition:
- Shared package sevenseg_pkg: the hex-to-segment decode function/constant table and a SEG_BLANK constant.
- Sub-module sevenseg_tick_gen (slot counter + tick), parametrised by DIV_W.
- Index, shadow, suppression and output registers stay in the top of the block.

Test Plan:
1. Reset, then release, with refresh_div=10, DEADTIME=4, load value=32'h89ABCDEF. Expect:
   - First wrap: frame_done pulse; active takes the value.
   - Next frame: each digit lit for 6 of 10 cycles.
   - Digit 0 shows sev_out=0111000 ('F') with an=11111110.
   - Digits advance in order 0..7; frame_done every 80 cycles.
2. Issue load of 32'h00000005 mid-frame. Expect the old value to persist until the next frame_done; all 8 digits then update in the same frame.
3. With lz_en=1, value=32'h00000120, blank_mask=0. Expect:
   - Digits 7..3 never assert an.
   - Digits 2..0 show '1','2','0'.
   - With value=0, only digit 0 shows '0'.
4. Set blank_mask=8'h0F, dp_mask=8'h11. Expect:
   - Digits 0..3 are never asserted.
   - Digit 4 is lit with dp_out=0.
   - Digit 0's dp is suppressed.
5. Set refresh_div=0, then 1. Expect:
   - The digit advances every cycle with no dead time.
   - Lowering refresh_div from 1000 to 5 at counter=700 produces a tick on the next cycle.
6. Drive Rst=0 for 1 cycle mid-slot while pending=1. Expect:
   - Next cycle: an all 1, sev_out=1111111, dp_out=1, frame_done=0.
   - The pending load is discarded, and the display shows 0 after the first frame.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Segment patterns are held in active-low form ({a,b,c,d,e,f,g}, bit6 = a);
// the top level inverts them for active-high boards.
package sevenseg_pkg;

  // All segments unlit, active-low form.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex nibble to active-low segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Bus bundle between the display client and the scan controller.
//   refresh_div : clk cycles per digit slot (0 behaves as 1)
//   value       : hex nibbles, digit i = value[4i+3:4i]
//   load        : 1-cycle strobe capturing value/dp_mask/blank_mask
//   dp_mask     : decimal point per digit
//   blank_mask  : force digit dark
//   lz_en       : leading-zero suppression enable
//   an          : anode drive (one-hot when asserted)
//   sev_out     : segments {a..g}
//   dp_out      : decimal point segment
//   frame_done  : 1-cycle pulse on digit index wrap
// master = client driving the display, slave = scan controller.
interface sevenseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_W      = 16
);
  logic [DIV_W-1:0]        refresh_div;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              sev_out;
  logic                    dp_out;
  logic                    frame_done;

  modport master (
    output refresh_div, value, load, dp_mask, blank_mask, lz_en,
    input  an, sev_out, dp_out, frame_done
  );

  modport slave (
    input  refresh_div, value, load, dp_mask, blank_mask, lz_en,
    output an, sev_out, dp_out, frame_done
  );
endinterface

// File: rtl/sevenseg_tick_gen.sv
// Slot counter for the scan controller.
//   clk, rst_n    : clock, synchronous active-low reset
//   refresh_div_i : requested slot length in clk cycles (0 behaves as 1)
//   tick_o        : last cycle of the current slot
//   cnt_o         : position inside the slot
//   div_eff_o     : effective slot length, max(refresh_div_i, 1)
module sevenseg_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] refresh_div_i,
  output logic             tick_o,
  output logic [DIV_W-1:0] cnt_o,
  output logic [DIV_W-1:0] div_eff_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    div_eff_o = (refresh_div_i == '0) ? DIV_W'(1) : refresh_div_i;
    // >= so that lowering the divider mid-slot ends the slot on the next cycle
    tick_o    = (cnt_q >= div_eff_o - DIV_W'(1));
    cnt_d     = tick_o ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multi-digit seven-segment scan controller.
// Time-multiplexes NUM_DIGITS hex digits onto shared segment lines with a
// runtime slot divider, frame-aligned shadow loading, per-digit blanking and
// decimal points, leading-zero suppression and anode dead time.
//   clk : system clock
//   Rst : synchronous active-low reset
//   bus : sevenseg_scan_ctrl_if slave (inputs, an/sev_out/dp_out/frame_done)
// an, sev_out and dp_out come from one register stage so they always move together.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV_W          = 16,
  parameter int DEADTIME       = 4,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic                clk,
  input logic                Rst,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam int                     IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0]  AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]             SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
  localparam logic                   DP_OFF   = (SEG_ACTIVE_LOW != 0);

  logic             tick;
  logic [DIV_W-1:0] cnt, div_eff, dead_lim;

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_bl_q, sh_bl_d, act_bl_q, act_bl_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d, fd_q, fd_d;

  logic                    wrap, dead, show_an;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_bl, cur_supp;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [6:0]              seg_lo;

  sevenseg_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk           (clk),
    .rst_n         (Rst),
    .refresh_div_i (bus.refresh_div),
    .tick_o        (tick),
    .cnt_o         (cnt),
    .div_eff_o     (div_eff)
  );

  // Current digit selection and leading-zero scan from the top digit down.
  always_comb begin : sel_blk
    logic zero_above;
    zero_above = 1'b1;
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_bl     = 1'b0;
    cur_supp   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (act_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib  = act_val_q[4*i +: 4];
        cur_dp   = act_dp_q[i];
        cur_bl   = act_bl_q[i];
        cur_supp = bus.lz_en & (i != 0) & zero_above;
      end
    end
  end

  always_comb begin
    wrap  = tick & (idx_q == LAST_IDX);
    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    // Shadow/active: content changes only on a frame wrap.
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_bl_d   = sh_bl_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_bl_d  = act_bl_q;
    pend_d    = pend_q;
    if (bus.load) begin
      sh_val_d = bus.value;
      sh_dp_d  = bus.dp_mask;
      sh_bl_d  = bus.blank_mask;
      pend_d   = 1'b1;
    end
    if (wrap) begin
      if (bus.load) begin
        act_val_d = bus.value;
        act_dp_d  = bus.dp_mask;
        act_bl_d  = bus.blank_mask;
      end else if (pend_q) begin
        act_val_d = sh_val_q;
        act_dp_d  = sh_dp_q;
        act_bl_d  = sh_bl_q;
      end
      pend_d = 1'b0;
    end

    // Dead time never swallows the whole slot: capped at div_eff-1.
    dead_lim = (DIV_W'(DEADTIME) < div_eff - DIV_W'(1)) ? DIV_W'(DEADTIME)
                                                        : div_eff - DIV_W'(1);
    dead     = (cnt < dead_lim);
    // A suppressed digit still drives its anode when it carries a decimal point.
    show_an  = ~cur_bl & ~dead & (~cur_supp | cur_dp);
    onehot   = NUM_DIGITS'(1) << idx_q;
    an_d     = show_an ? ((AN_ACTIVE_LOW != 0) ? ~onehot : onehot) : AN_OFF;
    seg_lo   = (show_an & ~cur_supp) ? hex_to_seg(cur_nib) : SEG_BLANK;
    seg_d    = (SEG_ACTIVE_LOW != 0) ? seg_lo : ~seg_lo;
    dp_d     = (show_an & cur_dp) ? ~DP_OFF : DP_OFF;
    fd_d     = wrap;
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      idx_q     <= '0;
      pend_q    <= 1'b0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_bl_q   <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_bl_q  <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
      fd_q      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_bl_q   <= sh_bl_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_bl_q  <= act_bl_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.sev_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural display model.
module tb_sevenseg_scan_ctrl;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int DT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_ctrl_if #(.NUM_DIGITS(N), .DIV_W(DW)) bus();

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(N), .DIV_W(DW), .DEADTIME(DT),
    .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  // Active-low glyphs for 0..F.
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_vec = 0;
  int n_err = 0;

  // Model: slot position, current digit, shown/pending frame content.
  int          m_cnt, m_idx;
  bit          m_pend;
  logic [31:0] sh_val, act_val;
  logic [7:0]  sh_dp, sh_bl, act_dp, act_bl;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s @%0t: got %h, want %h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs that were present before the edge.
  task automatic step_model();
    int eff, dl, nib;
    bit tick, dead, bl, dp, supp, show;
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_pend = 0;
      sh_val = 0; act_val = 0; sh_dp = 0; sh_bl = 0; act_dp = 0; act_bl = 0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      return;
    end
    eff  = (bus.refresh_div == 0) ? 1 : int'(bus.refresh_div);
    tick = (m_cnt >= eff - 1);
    dl   = (DT < eff - 1) ? DT : eff - 1;
    dead = (m_cnt < dl);
    nib  = int'((act_val >> (4 * m_idx)) & 32'hF);
    bl   = act_bl[m_idx];
    dp   = act_dp[m_idx];
    supp = bus.lz_en && (m_idx > 0) && ((act_val >> (4 * m_idx)) == 0);
    show = !bl && !dead && (!supp || dp);
    e_an  = show ? ~(8'(1) << m_idx) : 8'hFF;
    e_seg = (show && !supp) ? glyph[nib] : 7'h7F;
    e_dp  = (show && dp) ? 1'b0 : 1'b1;
    e_fd  = tick && (m_idx == N - 1);
    if (bus.load && e_fd) begin
      sh_val = bus.value; sh_dp = bus.dp_mask; sh_bl = bus.blank_mask;
      act_val = bus.value; act_dp = bus.dp_mask; act_bl = bus.blank_mask;
      m_pend = 0;
    end else begin
      if (e_fd && m_pend) begin
        act_val = sh_val; act_dp = sh_dp; act_bl = sh_bl;
        m_pend = 0;
      end
      if (bus.load) begin
        sh_val = bus.value; sh_dp = bus.dp_mask; sh_bl = bus.blank_mask;
        m_pend = 1;
      end
    end
    if (tick) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % N;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    step_model();
    chk("an", bus.an, e_an);
    chk("sev_out", bus.sev_out, e_seg);
    chk("dp_out", bus.dp_out, e_dp);
    chk("frame_done", bus.frame_done, e_fd);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dpm, input logic [7:0] blm);
    bus.value = v; bus.dp_mask = dpm; bus.blank_mask = blm; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.refresh_div = 16'd10;
    bus.value = '0; bus.load = 1'b0; bus.dp_mask = '0; bus.blank_mask = '0; bus.lz_en = 1'b0;
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;

    // Basic scan with refresh_div=10
    do_load(32'h89ABCDEF, 8'h00, 8'h00);
    run(250);

    // Mid-frame reload
    run(23);
    do_load(32'h00000005, 8'h00, 8'h00);
    run(200);

    // Leading-zero suppression
    bus.lz_en = 1'b1;
    do_load(32'h00000120, 8'h00, 8'h00);
    run(200);
    do_load(32'h00000000, 8'h00, 8'h00);
    run(200);

    // Blanking and decimal points (including dp on suppressed digits)
    do_load(32'h00012345, 8'h11, 8'h0F);
    run(200);
    do_load(32'h00000003, 8'hA0, 8'h00);
    run(200);
    bus.lz_en = 1'b0;

    // Divider 0 and 1: no dead time, advance every cycle
    bus.refresh_div = 16'd0;
    run(40);
    bus.refresh_div = 16'd1;
    run(40);

    // Lowering the divider mid-slot
    bus.refresh_div = 16'd1000;
    for (int k = 0; k < 2500 && m_cnt != 700; k++) cyc();
    chk("cnt700_reached", m_cnt, 32'd700);
    bus.refresh_div = 16'd5;
    run(60);

    // Reset mid-slot with a pending load
    bus.refresh_div = 16'd10;
    run(13);
    do_load(32'hDEADBEEF, 8'hFF, 8'h00);
    run(3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    run(200);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) bus.refresh_div = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) bus.lz_en = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 499) != 0);
      bus.value      = $urandom >> $urandom_range(0, 31);
      bus.dp_mask    = 8'($urandom);
      bus.blank_mask = 8'($urandom) & 8'($urandom);
      bus.load       = ($urandom_range(0, 19) == 0);
      cyc();
      bus.load = 1'b0;
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
